// File: rtl/add_unit_arbiter_pkg.sv
// Shared definitions for the add_unit_arbiter slice.
//   OPW       : operand width of the shared adder
//   RESW      : result width (operand width plus carry-out)
//   DEF_NREQ  : default number of requesters
//   DEF_TAGW  : default destination tag width
//   carry_out : rebuilds the adder carry-out from the top operand bits and
//               the top sum bit, so the adder itself only needs a 16-bit sum.
package add_unit_arbiter_pkg;

    localparam int OPW      = 16;
    localparam int RESW     = 17;
    localparam int DEF_NREQ = 4;
    localparam int DEF_TAGW = 4;

    // Both MSBs set always carries. With exactly one MSB set, the sum bit is
    // the inverse of the carry into bit 15, and that carry is also the
    // carry-out.
    function automatic logic carry_out(input logic a15, input logic b15, input logic s15);
        return (a15 & b15) | ((a15 ^ b15) & ~s15);
    endfunction

endpackage

// File: rtl/add_unit_arbiter_cla.sv
// 16-bit carry-lookahead adder (no carry-in; carry-out is rebuilt by the caller).
// Ports:
//   a   in  16  operand A
//   b   in  16  operand B
//   sum out 16  (a + b) mod 2^16
// Built from 4-bit lookahead groups. Each group's carry-in comes from the
// previous group's generate/propagate terms.
module add_unit_arbiter_cla
    import add_unit_arbiter_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [OPW-1:0] sum
);

    localparam int GRPW = 4;
    localparam int NGRP = OPW / GRPW;

    logic [OPW-1:0]  g;
    logic [OPW-1:0]  p;
    logic [OPW-1:0]  c;
    logic [NGRP-1:0] grp_cin;

    assign g = a & b;
    assign p = a ^ b;
    assign grp_cin[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            localparam int B = gi * GRPW;

            // Bit carries inside the group, fully expanded from the group carry-in.
            assign c[B]     = grp_cin[gi];
            assign c[B + 1] = g[B] | (p[B] & grp_cin[gi]);
            assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B])
                            | (p[B + 1] & p[B] & grp_cin[gi]);
            assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1])
                            | (p[B + 2] & p[B + 1] & g[B])
                            | (p[B + 2] & p[B + 1] & p[B] & grp_cin[gi]);

            // The last group's carry-out is not needed here.
            if (gi < NGRP - 1) begin : g_next
                logic grp_g;
                logic grp_p;
                assign grp_g = g[B + 3] | (p[B + 3] & g[B + 2])
                             | (p[B + 3] & p[B + 2] & g[B + 1])
                             | (p[B + 3] & p[B + 2] & p[B + 1] & g[B]);
                assign grp_p = &p[B +: GRPW];
                assign grp_cin[gi + 1] = grp_g | (grp_p & grp_cin[gi]);
            end
        end
    endgenerate

    assign sum = p ^ c;

endmodule

// File: rtl/add_unit_arbiter.sv
// Round-robin arbiter in front of one shared 16-bit adder, with a two-stage
// pipeline: an issue register, then a result register.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   req_valid  [NREQ]       per-requester request
//   req_ready  [NREQ]       one-hot grant (a transfer is valid & ready)
//   req_a/b    [NREQ*16]    operands, requester i at [16i+15:16i]
//   req_tag    [NREQ*TAGW]  destination tags, same packing
//   res_valid/res_ready     result handshake
//   res_sum    [17]         a+b, bit 16 is the carry-out
//   res_tag    [TAGW]       tag of the result
//   res_src    [SRCW]       index of the issuing requester
//   busy                    either pipeline stage occupied
module add_unit_arbiter
    import add_unit_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int TAGW = DEF_TAGW,
    parameter int SRCW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_a,
    input  logic [NREQ*OPW-1:0]  req_b,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RESW-1:0]      res_sum,
    output logic [TAGW-1:0]      res_tag,
    output logic [SRCW-1:0]      res_src,
    output logic                 busy
);

    // Unpacked views of the packed request buses.
    logic [OPW-1:0]  a_arr   [NREQ];
    logic [OPW-1:0]  b_arr   [NREQ];
    logic [TAGW-1:0] tag_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]   = req_a[gi*OPW +: OPW];
            assign b_arr[gi]   = req_b[gi*OPW +: OPW];
            assign tag_arr[gi] = req_tag[gi*TAGW +: TAGW];
        end
    endgenerate

    // Pipeline state
    logic [SRCW-1:0] ptr_reg;
    logic [SRCW-1:0] ptr_next;
    logic            s1_valid_reg;
    logic [OPW-1:0]  s1_a_reg;
    logic [OPW-1:0]  s1_b_reg;
    logic [TAGW-1:0] s1_tag_reg;
    logic [SRCW-1:0] s1_src_reg;
    logic            res_valid_reg;
    logic [RESW-1:0] res_sum_reg;
    logic [TAGW-1:0] res_tag_reg;
    logic [SRCW-1:0] res_src_reg;

    // Flow control
    logic stall2;
    logic adv1;
    logic can_issue;

    assign stall2    = res_valid_reg & ~res_ready;
    assign adv1      = s1_valid_reg & ~stall2;
    assign can_issue = ~s1_valid_reg | adv1;

    // Round-robin search. Two lowest-index searches are done in one pass:
    // one over requests at or above the pointer, and one over all requests.
    // The first search wins if it finds anything. Otherwise the second
    // search gives the wrap-around choice.
    logic            hi_found;
    logic            lo_found;
    logic [SRCW-1:0] hi_idx;
    logic [SRCW-1:0] lo_idx;
    logic [SRCW-1:0] gnt_idx;
    logic            gnt_valid;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = SRCW'(i);
                if (SRCW'(i) >= ptr_reg) begin
                    hi_found = 1'b1;
                    hi_idx   = SRCW'(i);
                end
            end
        end
    end

    assign gnt_idx   = hi_found ? hi_idx : lo_idx;
    // A grant is only ever given to a valid requester, so a grant is a transfer.
    assign gnt_valid = (hi_found | lo_found) & can_issue & ~rst;

    always_comb begin
        req_ready = '0;
        if (gnt_valid) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (gnt_valid) begin
            ptr_next = (gnt_idx == SRCW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Shared adder between the stages.
    logic [OPW-1:0]  cla_sum;
    logic [RESW-1:0] sum_full;

    add_unit_arbiter_cla u_cla (
        .a   (s1_a_reg),
        .b   (s1_b_reg),
        .sum (cla_sum)
    );

    assign sum_full = {carry_out(s1_a_reg[OPW-1], s1_b_reg[OPW-1], cla_sum[OPW-1]), cla_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_tag_reg    <= '0;
            s1_src_reg    <= '0;
            res_valid_reg <= 1'b0;
            res_sum_reg   <= '0;
            res_tag_reg   <= '0;
            res_src_reg   <= '0;
        end else begin
            ptr_reg <= ptr_next;

            if (gnt_valid) begin
                s1_valid_reg <= 1'b1;
                s1_a_reg     <= a_arr[gnt_idx];
                s1_b_reg     <= b_arr[gnt_idx];
                s1_tag_reg   <= tag_arr[gnt_idx];
                s1_src_reg   <= gnt_idx;
            end else if (adv1) begin
                s1_valid_reg <= 1'b0;
            end

            // Stage-2 data only changes on adv1, so it holds while stalled.
            if (adv1) begin
                res_valid_reg <= 1'b1;
                res_sum_reg   <= sum_full;
                res_tag_reg   <= s1_tag_reg;
                res_src_reg   <= s1_src_reg;
            end else if (res_valid_reg & res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign res_valid = res_valid_reg;
    assign res_sum   = res_sum_reg;
    assign res_tag   = res_tag_reg;
    assign res_src   = res_src_reg;
    assign busy      = s1_valid_reg | res_valid_reg;

endmodule

// File: tb/tb_add_unit_arbiter.sv
module tb_add_unit_arbiter;

    localparam int NREQ = 4;
    localparam int TAGW = 4;
    localparam int SRCW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*16-1:0]   req_b;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 res_valid;
    logic                 res_ready;
    logic [16:0]          res_sum;
    logic [TAGW-1:0]      res_tag;
    logic [SRCW-1:0]      res_src;
    logic                 busy;

    add_unit_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .SRCW(SRCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_tag   (res_tag),
        .res_src   (res_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard model. Results are kept in grant order. The pipeline holds
    // at most two operations, so a new grant is possible unless two are
    // outstanding and the result is not taken.
    typedef struct {
        logic [16:0]     sum;
        logic [TAGW-1:0] tag;
        logic [SRCW-1:0] src;
    } res_t;

    res_t            exp_q[$];
    res_t            m_front;
    res_t            m_new;
    bit              mon_en = 0;
    int              mptr = 0;
    int              m_qs;
    int              m_idx;
    int              m_c;
    logic [NREQ-1:0] m_eg;
    bit              m_stalled = 0;
    logic [31:0]     m_held;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                mptr      = 0;
                m_stalled = 0;
            end else begin
                m_qs = exp_q.size();
                if (m_stalled) begin
                    check("stall_hold_valid", {31'd0, res_valid}, 32'd1);
                    check("stall_hold_data", {9'd0, res_sum, res_tag, res_src}, m_held);
                end
                m_idx = -1;
                for (int k = 0; k < NREQ; k++) begin
                    m_c = (mptr + k) % NREQ;
                    if (m_idx < 0 && req_valid[m_c]) m_idx = m_c;
                end
                m_eg = '0;
                if (m_idx >= 0 && (m_qs < 2 || res_ready)) m_eg[m_idx] = 1'b1;
                check("grant", {28'd0, req_ready}, {28'd0, m_eg});
                check("busy", {31'd0, busy}, {31'd0, m_qs != 0});
                if (res_valid && res_ready) begin
                    if (m_qs == 0) begin
                        total++;
                        bad++;
                        $display("FAIL orphan_result: got sum=%05h src=%0d want no result", res_sum, res_src);
                    end else begin
                        m_front = exp_q.pop_front();
                        check("res_sum", {15'd0, res_sum}, {15'd0, m_front.sum});
                        check("res_tag", {28'd0, res_tag}, {28'd0, m_front.tag});
                        check("res_src", {30'd0, res_src}, {30'd0, m_front.src});
                        $display("result src=%0d tag=%0h sum=%05h", res_src, res_tag, res_sum);
                    end
                end
                if ((req_valid & req_ready) != '0 && m_idx >= 0) begin
                    m_new.sum = {1'b0, req_a[m_idx*16 +: 16]} + {1'b0, req_b[m_idx*16 +: 16]};
                    m_new.tag = req_tag[m_idx*TAGW +: TAGW];
                    m_new.src = SRCW'(m_idx);
                    exp_q.push_back(m_new);
                    mptr = (m_idx + 1) % NREQ;
                end
                m_stalled = res_valid && !res_ready;
                m_held    = {9'd0, res_sum, res_tag, res_src};
            end
        end
    end

    typedef struct {
        logic [15:0]     a;
        logic [15:0]     b;
        logic [TAGW-1:0] tag;
        int              src;
        logic [16:0]     sum;
    } vec_t;

    vec_t vecs[7];

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] gl;
    int              ops;
    int              cyc;
    int              gcount;

    initial begin
        vecs[0] = '{a: 16'h1234, b: 16'h0001, tag: 4'h5, src: 0, sum: 17'h01235};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, tag: 4'h1, src: 1, sum: 17'h10000};
        vecs[2] = '{a: 16'h8000, b: 16'h8000, tag: 4'h2, src: 2, sum: 17'h10000};
        vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, tag: 4'h3, src: 3, sum: 17'h1FFFE};
        vecs[4] = '{a: 16'h0000, b: 16'h0000, tag: 4'hF, src: 0, sum: 17'h00000};
        vecs[5] = '{a: 16'h7FFF, b: 16'h0001, tag: 4'hA, src: 2, sum: 17'h08000};
        vecs[6] = '{a: 16'hA5A5, b: 16'h5A5A, tag: 4'h9, src: 1, sum: 17'h0FFFF};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en    = 1;
        req_valid = '1;
        #1;
        check("ready_in_reset", {28'd0, req_ready}, 32'd0);
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_res_data", {9'd0, res_sum, res_tag, res_src}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // Table of single operations, one at a time, checking the latency.
        for (int v = 0; v < 7; v++) begin
            req_valid = '0;
            req_valid[vecs[v].src] = 1'b1;
            req_a[vecs[v].src*16 +: 16]     = vecs[v].a;
            req_b[vecs[v].src*16 +: 16]     = vecs[v].b;
            req_tag[vecs[v].src*TAGW +: TAGW] = vecs[v].tag;
            #1;
            check("vec_grant", {28'd0, req_ready}, 32'd1 << vecs[v].src);
            @(posedge clk);
            #1;
            req_valid = '0;
            check("vec_early_valid", {31'd0, res_valid}, 32'd0);
            @(posedge clk);
            #1;
            check("vec_res_valid", {31'd0, res_valid}, 32'd1);
            check("vec_res_sum", {15'd0, res_sum}, {15'd0, vecs[v].sum});
            check("vec_res_tag", {28'd0, res_tag}, {28'd0, vecs[v].tag});
            check("vec_res_src", {30'd0, res_src}, vecs[v].src);
            @(posedge clk);
            #1;
        end

        // Round robin with all requesters active and no backpressure.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*16 +: 16]     = 16'h1111 * 16'(i + 1);
            req_b[i*16 +: 16]     = 16'(i);
            req_tag[i*TAGW +: TAGW] = TAGW'(i + 8);
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_grant", {28'd0, req_ready}, 32'd1 << (k % NREQ));
            if (k >= 2) begin
                check("rr_res_valid", {31'd0, res_valid}, 32'd1);
                check("rr_res_src", {30'd0, res_src}, (k - 2) % NREQ);
            end
            @(posedge clk);
            #1;
        end

        // Backpressure: two grants fill the pipeline, then nothing moves.
        req_valid = '0;
        do_reset();
        req_valid = '1;
        res_ready = 1'b0;
        gcount    = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            gcount += $countones(req_ready);
            if (k >= 2) check("bp_res_src", {30'd0, res_src}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("bp_grant_count", gcount, 32'd2);
        res_ready = 1'b1;
        #1;
        check("bp_release_grant", {28'd0, req_ready}, 32'h4);
        check("bp_release_src0", {30'd0, res_src}, 32'd0);
        @(posedge clk);
        #2;
        check("bp_drain_valid", {31'd0, res_valid}, 32'd1);
        check("bp_drain_src1", {30'd0, res_src}, 32'd1);
        check("bp_next_grant", {28'd0, req_ready}, 32'h8);

        // Reset with both stages full: nothing in flight may come out later.
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midop_full", {30'd0, busy, res_valid}, 32'd3);
        rst = 1'b1;
        #1;
        check("midop_ready_in_reset", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        #1;
        check("midop_res_valid", {31'd0, res_valid}, 32'd0);
        check("midop_busy", {31'd0, busy}, 32'd0);
        check("midop_ptr0_grant", {28'd0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Random traffic; requesters hold their request until granted.
        pending = '0;
        gl      = '0;
        ops     = 0;
        cyc     = 0;
        while (ops < 10000 && cyc < 40000) begin
            pending = pending & ~gl;
            ops += $countones(gl);
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 2) != 0) begin
                    pending[i] = 1'b1;
                    req_a[i*16 +: 16]       = 16'($urandom);
                    req_b[i*16 +: 16]       = 16'($urandom);
                    req_tag[i*TAGW +: TAGW] = TAGW'($urandom);
                end
            end
            req_valid = pending;
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            gl = req_valid & req_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("random_ops_done", {31'd0, ops >= 10000}, 32'd1);

        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
